// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO drain arbiter: FSM state encoding and
// the bit-width helper used to size counters and channel indices.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // Number of bits needed to represent 'value' (0 -> 0, 1 -> 1, 3 -> 2, 4 -> 3).
  function automatic int clogb2(input int value);
    int n;
    n = 0;
    for (int v = value; v > 0; v = v >> 1) begin
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// Stream bus carrying drained FIFO words from the arbiter to the shared
// readout path.
interface fifo_drain_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 2
);
  import fifo_arb_pkg::*;

  // A beat transfers on a rising edge where tvalid and tready are both high.
  // Once tvalid is raised, tdata/tuser/tlast hold steady and tvalid stays high
  // until that transfer; tready may change freely and never gates tvalid.
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata,
    output tvalid,
    input  tready,
    output tlast,
    output tuser
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready,
    input  tlast,
    input  tuser
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo
// CH_NUM. Purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int CH_W   = 2
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  logic [CH_NUM-1:0] rot;
  int                sel;

  // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot = '0;
    sel = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      rot[i] = req[(i + int'(ptr)) % CH_NUM];
    end
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sel = i;
      end
    end
    found = |req;
    idx   = CH_W'((sel + int'(ptr)) % CH_NUM);
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains CH_NUM FWFT channel FIFOs into one stream, one bounded burst at a
// time, round-robin with priority for channels reporting programmable-full.
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  CH_NUM     = 4,
  parameter int  DATA_WIDTH = 64,
  parameter int  MAX_BURST  = 16,
  localparam int CH_W       = (clogb2(CH_NUM - 1) > 1) ? clogb2(CH_NUM - 1) : 1,
  localparam int CNT_W      = clogb2(MAX_BURST + 1)
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         ENABLE,
  input  logic [CH_NUM-1:0]            FIFO_NOT_EMPTY,
  input  logic [CH_NUM-1:0]            FIFO_PROG_FULL,
  input  logic [CH_NUM*DATA_WIDTH-1:0] FIFO_DOUT,
  output logic [CH_NUM-1:0]            FIFO_RE,
  fifo_drain_arbiter_if.master         m_axis,
  output logic                         BUSY,
  output arb_state_e                   DBG_STATE,
  output logic [CH_W-1:0]              DBG_RR_PTR
);

  arb_state_e            state_q, state_d;
  logic [CH_W-1:0]       gnt_q;
  logic [CH_W-1:0]       rr_ptr_q;
  logic [CNT_W-1:0]      beat_cnt_q;
  logic [DATA_WIDTH-1:0] hold_q;

  logic [DATA_WIDTH-1:0] tdata_q;
  logic [CH_W-1:0]       tuser_q;
  logic                  tlast_q;
  logic                  tvalid_q;

  logic [CH_NUM-1:0]     pf_req;
  logic                  pf_found, ne_found;
  logic [CH_W-1:0]       pf_idx, ne_idx, pick_idx;

  logic                  grant_ld, read_ld, out_ld, last, out_free;

  // Full channels are picked from their own ring so they preempt the rest.
  assign pf_req = FIFO_NOT_EMPTY & FIFO_PROG_FULL;

  rr_pick #(.CH_NUM(CH_NUM), .CH_W(CH_W)) u_pick_pf (
    .req   (pf_req),
    .ptr   (rr_ptr_q),
    .found (pf_found),
    .idx   (pf_idx)
  );

  rr_pick #(.CH_NUM(CH_NUM), .CH_W(CH_W)) u_pick_ne (
    .req   (FIFO_NOT_EMPTY),
    .ptr   (rr_ptr_q),
    .found (ne_found),
    .idx   (ne_idx)
  );

  assign pick_idx = pf_found ? pf_idx : ne_idx;
  assign out_free = !tvalid_q || m_axis.tready;

  always_comb begin
    state_d  = state_q;
    grant_ld = 1'b0;
    read_ld  = 1'b0;
    out_ld   = 1'b0;
    last     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ENABLE && ne_found) begin
          grant_ld = 1'b1;
          state_d  = READ;
        end
      end
      READ: begin
        read_ld = 1'b1;
        state_d = GAP;
      end
      GAP: begin
        // NOT_EMPTY has caught up with the read issued in READ by now.
        last = (beat_cnt_q == CNT_W'(MAX_BURST)) || !FIFO_NOT_EMPTY[gnt_q];
        if (out_free) begin
          out_ld  = 1'b1;
          state_d = last ? IDLE : READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_ld) begin
        gnt_q      <= pick_idx;
        beat_cnt_q <= '0;
      end
      if (read_ld) begin
        hold_q     <= FIFO_DOUT[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
      if (out_ld && last) begin
        rr_ptr_q <= (gnt_q == CH_W'(CH_NUM - 1)) ? '0 : gnt_q + CH_W'(1);
      end
    end
  end

  // Output register: reloads from hold_q, otherwise drops valid once taken.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tdata_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (out_ld) begin
      tdata_q  <= hold_q;
      tuser_q  <= gnt_q;
      tlast_q  <= last;
      tvalid_q <= 1'b1;
    end else if (m_axis.tready) begin
      tvalid_q <= 1'b0;
    end
  end

  always_comb begin
    FIFO_RE = '0;
    if (state_q == READ) begin
      FIFO_RE[gnt_q] = 1'b1;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tvalid = tvalid_q;

  assign BUSY       = (state_q != IDLE);
  assign DBG_STATE  = state_q;
  assign DBG_RR_PTR = rr_ptr_q;

endmodule
